mac_unit: RTL and testbench
===========================

Name: mac_unit

Overview:
- Processing element of a 3x3 output-stationary systolic matrix multiplier.
- Each clock with start high, multiplies the incoming A and B operands and accumulates the product into a local result C.
- Independently forwards A to the neighbour below and B to the neighbour on the right through one-cycle pipeline registers.
- Nine instances form the array; C of each instance is one element of the product matrix.

Parameters:
- DATA_W, 8, width of A, B, pass_A, pass_B and C.
- SATURATE, 0, 0 = C wraps modulo 2^DATA_W; 1 = C clamps at 2^DATA_W-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all registers.
- start  input  1  accumulate enable for the current cycle's A/B pair.
- A  input  DATA_W  row operand (unsigned).
- B  input  DATA_W  column operand (unsigned).
- pass_A  output  DATA_W  A delayed one cycle, to next PE in the column.
- pass_B  output  DATA_W  B delayed one cycle, to next PE in the row.
- C  output  DATA_W  accumulated result (registered).

Behaviour:
- Reset is asynchronous, active-high; clock is clk. While reset is high: C=0, pass_A=0, pass_B=0, internal start_d=0. Reset mid-burst discards the partial sum immediately.
- Pass registers, every rising edge regardless of start: pass_A <= A, pass_B <= B. Latency is 1 cycle. Zero operands pass through as zeros.
- Product: full 2*DATA_W-bit unsigned product P = A*B.
- Accumulation, on a rising edge with start=1:
  - If start_d=0 (first cycle of a burst): C <= P reduced to DATA_W. The previous result is cleared, not added to.
  - If start_d=1 (burst continuing): C <= C + P, reduced to DATA_W.
- start=0: C holds its value indefinitely. This is the result-valid window.
- start_d <= start every cycle. It is the only state besides C and the pass registers.
- Reduction:
  - SATURATE=0: keep the low DATA_W bits of the sum (modulo 2^DATA_W).
  - SATURATE=1: compute the sum at 2*DATA_W+1 bits; if it exceeds 2^DATA_W-1, C <= 2^DATA_W-1. Once saturated, C stays saturated until the next burst start.
- Latency: C reflects the operand pair sampled at edge k immediately after edge k (1 cycle). An N-term dot product is complete one cycle after the last start=1 edge.
- Operands are unsigned; no signed mode.
- No X propagation: all outputs are defined after reset.
- Bursts separated by at least one start=0 cycle are independent results. A continuous start=1 stream is a single sum.

Test Plan:
- Reset: assert reset asynchronously with no clock edge -> C=0, pass_A=0, pass_B=0 immediately. Release, start=0 for 3 cycles -> C stays 0.
- Dot product: start=1 for 3 cycles with (A,B)=(1,2),(3,4),(5,6), then start=0 -> C=2, 14, 44 after successive edges; C holds 44 afterwards.
- Burst restart: after the previous test, start=0 for 2 cycles, then start=1 with (A,B)=(2,3) -> C=6 (not 50). Next edge with start=1, (4,4) -> C=22.
- Pass-through: drive A=0x11,0x22,0x33 and B=0xA1,0xA2,0xA3 on consecutive edges, start toggling randomly -> pass_A/pass_B equal the previous cycle's A/B every cycle, independent of start.
- Wrap vs saturate: burst (16,16),(15,17).
  - SATURATE=0 -> C=0, then 255.
  - SATURATE=1 -> C=255, then 255.
  - A third term (1,1): SATURATE=0 -> C=0; SATURATE=1 -> C=255.
- Reset mid-burst: burst (7,7),(7,7), assert reset between edges -> C=0 at once. Release, start=1 with (1,1) -> C=1.

Source files
------------

// File: rtl/mac_unit.sv
// mac_unit: one processing element of a 3x3 output-stationary systolic
// matrix multiplier. It multiplies A by B and accumulates the product into C
// while start is high. A and B are forwarded to the neighbouring PEs through
// one-cycle pipeline registers. A start burst that follows an idle cycle
// begins a fresh sum. With SATURATE=1, C clamps at the all-ones value.
module mac_unit #(
    parameter int DATA_W   = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] pass_A,
    output logic [DATA_W-1:0] pass_B,
    output logic [DATA_W-1:0] C
);

    localparam int SUM_W = 2 * DATA_W + 1;
    localparam logic [SUM_W-1:0] C_MAX = {{(DATA_W + 1){1'b0}}, {DATA_W{1'b1}}};

    logic                start_d;
    logic [2*DATA_W-1:0] prod;
    logic [SUM_W-1:0]    base;
    logic [SUM_W-1:0]    sum;
    logic [DATA_W-1:0]   c_next;

    assign prod = A * B;

    // Next accumulator value. The first cycle of a burst drops the old result.
    // Saturation is sticky: once C is all-ones, adding P >= 0 keeps the sum
    // at or above the clamp value until the next burst restarts the sum.
    always_comb begin
        base   = '0;
        sum    = '0;
        c_next = '0;
        if (start_d) begin
            base = {{(DATA_W + 1){1'b0}}, C};
        end
        sum = {1'b0, prod} + base;
        if (SATURATE && (sum > C_MAX)) begin
            c_next = {DATA_W{1'b1}};
        end else begin
            c_next = sum[DATA_W-1:0];
        end
    end

    // Forward the operands to the neighbours on every edge, whatever start is.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pass_A <= '0;
            pass_B <= '0;
        end else begin
            pass_A <= A;
            pass_B <= B;
        end
    end

    // Track the burst boundary, and accumulate while start is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_d <= 1'b0;
            C       <= '0;
        end else begin
            start_d <= start;
            if (start) begin
                C <= c_next;
            end
        end
    end

endmodule

// File: tb/tb_mac_unit.sv
// Directed testbench for mac_unit. Two instances share the same stimulus:
// one wraps (SATURATE=0) and one clamps (SATURATE=1).
module tb_mac_unit;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] pass_A_w, pass_B_w, C_w;
    logic [7:0] pass_A_s, pass_B_s, C_s;

    int n_total;
    int n_pass;

    mac_unit #(.DATA_W(8), .SATURATE(1'b0)) dut_wrap (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .A      (A),
        .B      (B),
        .pass_A (pass_A_w),
        .pass_B (pass_B_w),
        .C      (C_w)
    );

    mac_unit #(.DATA_W(8), .SATURATE(1'b1)) dut_sat (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .A      (A),
        .B      (B),
        .pass_A (pass_A_s),
        .pass_B (pass_B_s),
        .C      (C_s)
    );

    // 10-time-unit clock, first rising edge at 5
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)", tag, obs, obs, exp, exp);
    endtask

    // Drive one operand pair before an edge, then sample just after that edge.
    task automatic step(input logic s, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        start = s;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_c(input string tag, input logic [7:0] exp_w, input logic [7:0] exp_s);
        chk({tag, "_wrap"}, C_w, exp_w);
        chk({tag, "_sat"},  C_s, exp_s);
    endtask

    logic [7:0] pa_list [3];
    logic [7:0] pb_list [3];

    initial begin
        n_total = 0;
        n_pass  = 0;
        reset   = 1'b0;
        start   = 1'b0;
        A       = 8'h00;
        B       = 8'h00;
        pa_list[0] = 8'h11; pa_list[1] = 8'h22; pa_list[2] = 8'h33;
        pb_list[0] = 8'hA1; pb_list[1] = 8'hA2; pb_list[2] = 8'hA3;

        // Asynchronous reset before any clock edge
        #2 reset = 1'b1;
        #1;
        chk_c("reset_c", 8'd0, 8'd0);
        chk("reset_pass_A", pass_A_w, 8'd0);
        chk("reset_pass_B", pass_B_w, 8'd0);
        chk("reset_pass_A_sat", pass_A_s, 8'd0);
        @(negedge clk);
        reset = 1'b0;

        // Idle after reset: C stays 0
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'd0, 8'd0);
            chk_c("idle_c", 8'd0, 8'd0);
        end

        // Dot product 1*2 + 3*4 + 5*6
        step(1'b1, 8'd1, 8'd2); chk_c("dot_1", 8'd2,  8'd2);
        step(1'b1, 8'd3, 8'd4); chk_c("dot_2", 8'd14, 8'd14);
        step(1'b1, 8'd5, 8'd6); chk_c("dot_3", 8'd44, 8'd44);
        step(1'b0, 8'd9, 8'd9); chk_c("dot_hold1", 8'd44, 8'd44);
        step(1'b0, 8'd9, 8'd9); chk_c("dot_hold2", 8'd44, 8'd44);

        // New burst clears the previous result
        step(1'b1, 8'd2, 8'd3); chk_c("restart_1", 8'd6,  8'd6);
        step(1'b1, 8'd4, 8'd4); chk_c("restart_2", 8'd22, 8'd22);

        // Pass-through with start toggling randomly
        for (int i = 0; i < 3; i++) begin
            step(1'($urandom_range(0, 1)), pa_list[i], pb_list[i]);
            chk("pass_A", pass_A_w, pa_list[i]);
            chk("pass_B", pass_B_w, pb_list[i]);
            chk("pass_A_sat", pass_A_s, pa_list[i]);
            chk("pass_B_sat", pass_B_s, pb_list[i]);
        end
        step(1'b0, 8'd0, 8'd0);
        chk("pass_A_zero", pass_A_w, 8'd0);
        chk("pass_B_zero", pass_B_w, 8'd0);

        // Wrap vs saturate: 16*16=256, +15*17=255, +1*1
        step(1'b0, 8'd0, 8'd0);
        step(1'b1, 8'd16, 8'd16); chk_c("ovf_1", 8'd0,   8'd255);
        step(1'b1, 8'd15, 8'd17); chk_c("ovf_2", 8'd255, 8'd255);
        step(1'b1, 8'd1,  8'd1);  chk_c("ovf_3", 8'd0,   8'd255);
        step(1'b0, 8'd0,  8'd0);  chk_c("ovf_hold", 8'd0, 8'd255);

        // Reset between edges in the middle of a burst
        step(1'b1, 8'd7, 8'd7); chk_c("mid_1", 8'd49, 8'd49);
        step(1'b1, 8'd7, 8'd7); chk_c("mid_2", 8'd98, 8'd98);
        #2;
        reset = 1'b1;
        start = 1'b0;
        A     = 8'd0;
        B     = 8'd0;
        #1;
        chk_c("mid_reset_c", 8'd0, 8'd0);
        chk("mid_reset_pass_A", pass_A_w, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 8'd1, 8'd1); chk_c("post_reset", 8'd1, 8'd1);
        chk("post_reset_pass_A", pass_A_w, 8'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
